matmul_sched: RTL and testbench
===============================

MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 Parameter M, default 8: square matrix dimension; SHALL be a multiple of N1 and of N2.
REQ-002 Parameter N1, default 4: A bank count and systolic array rows.
REQ-003 Parameter N2, default 4: B bank count and systolic array columns.
REQ-004 Parameter D_W, default 8: element width, used only for documentation of the attached datapath.
REQ-005 fclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  load-complete pulse or level from the stream loader; sampled only in IDLE.
REQ-008 res_ready  in  1  result sink accepts the current tile's results.
REQ-009 rd_addr_A  out  $clog2(M*M/N1)  read address broadcast to all A banks.
REQ-010 rd_addr_B  out  $clog2(M*M/N2)  read address broadcast to all B banks.
REQ-011 rd_en  out  1  bank read enable.
REQ-012 acc_clr  out  1  clears array accumulators, asserted with the first read of each tile.
REQ-013 res_valid  out  1  tile results are stable and offered to the sink.
REQ-014 tile_row / tile_col  out  $clog2(M/N1) / $clog2(M/N2)  indices of the current tile.
REQ-015 busy  out  1  high in every state other than IDLE.
REQ-016 done  out  1  single-cycle pulse after the last tile is accepted.

Function
REQ-017 States: IDLE, STREAM, DRAIN, OFFER, DONE.
REQ-018 IDLE -> STREAM when start=1; tile_row=0, tile_col=0, k=0.
REQ-019 STREAM: for k=0..M-1, one per cycle, rd_en=1, rd_addr_A=tile_row*M+k, rd_addr_B=tile_col*M+k.
REQ-020 STREAM: acc_clr=1 exactly when k=0.
REQ-021 STREAM -> DRAIN after the k=M-1 cycle; DRAIN lasts N1+N2-1 cycles with rd_en=0.
REQ-022 DRAIN -> OFFER; res_valid=1 in OFFER until res_ready=1, with no timeout.
REQ-023 OFFER with res_ready=1: advance tile_col; on wrap from M/N2-1 to 0, advance tile_row; return to STREAM.
REQ-024 The handshake on the last tile (tile_row=M/N1-1, tile_col=M/N2-1) SHALL go to DONE instead of STREAM.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=0 from IDLE onward.
REQ-026 start while busy=1 SHALL be ignored; start held high through DONE SHALL restart only from IDLE.
REQ-027 res_ready outside OFFER SHALL be ignored.
REQ-028 Addresses SHALL be zero-extended arithmetic with no overflow, since the maximum is M*M/N1-1.
REQ-029 rd_addr_A and rd_addr_B SHALL hold 0 whenever rd_en=0.
REQ-030 Total cycles from start to done SHALL be (M/N1)*(M/N2)*(M+N1+N2) + 1 when res_ready is tied high.

Reset
REQ-031 rst=1 SHALL force IDLE with all outputs 0, including k, tile_row and tile_col.
REQ-032 Reset mid-operation SHALL abort with no done pulse; the next start runs from tile (0,0).

Configuration
REQ-033 Macro MATMUL_SCHED_PERF_EN present: adds output stall_cnt, 32 bits, which counts OFFER cycles with res_ready=0.
REQ-034 stall_cnt SHALL clear on reset and on each IDLE -> STREAM transition, and saturate at all-ones.
REQ-035 Macro absent: no stall_cnt port and no counter logic.

Structure
REQ-036 A shared package SHALL hold the state enum and the address-width localparams derived from M, N1 and N2.
REQ-037 One sub-module, sched_tile_cnt, SHALL implement the nested tile_col/tile_row counter with wrap and last-tile flag.
REQ-038 All control SHALL be a single FSM in matmul_sched.

Verification
REQ-039 M=8, N1=N2=4, res_ready=1, start pulse: 4 tiles; each tile has 8 rd_en cycles then 7 drain cycles; done asserts 65 cycles after start.
REQ-040 Tile (1,0): rd_addr_A = 8..15 and rd_addr_B = 0..7 on consecutive cycles; acc_clr high only with address pair (8,0).
REQ-041 res_ready low for 5 cycles in tile 0's OFFER: res_valid held for those 5 cycles, tile indices frozen, stall_cnt=5 when MATMUL_SCHED_PERF_EN is defined.
REQ-042 start re-pulsed during STREAM: no effect; sequence and done timing identical to REQ-039.
REQ-043 rst asserted in DRAIN of tile 2: next cycle IDLE, all outputs 0, no done; a new start sequences from tile (0,0).
REQ-044 M=8, N1=2, N2=4: 8 tiles, drain 5 cycles, rd_addr_A reaches 31, done after 8*14+1 cycles.

Source files
------------

// File: rtl/matmul_sched_pkg.sv
// Shared types and sizing helpers for the matmul tile scheduler.
// Default dimensions match the 8x8 array with 4x4 banking.
package matmul_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StDrain,
        StOffer,
        StDone
    } state_e;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MDefault  = 8;
    localparam int unsigned N1Default = 4;
    localparam int unsigned N2Default = 4;
    localparam int unsigned DwDefault = 8;

    localparam int unsigned AddrAWidth = clog2_min1(MDefault * MDefault / N1Default);
    localparam int unsigned AddrBWidth = clog2_min1(MDefault * MDefault / N2Default);
    localparam int unsigned RowWidth   = clog2_min1(MDefault / N1Default);
    localparam int unsigned ColWidth   = clog2_min1(MDefault / N2Default);

endpackage

// File: rtl/matmul_sched_tile_cnt.sv
// Nested tile counter: column is the fast index, row advances on column wrap.
// last_o flags the final tile of the matrix.
module sched_tile_cnt
    import matmul_sched_pkg::*;
#(
    parameter int unsigned Rows = 2,
    parameter int unsigned Cols = 2,
    localparam int unsigned RW  = clog2_min1(Rows),
    localparam int unsigned CW  = clog2_min1(Cols)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_last, col_last;

    assign row_last = (row_q == RW'(Rows - 1));
    assign col_last = (col_q == CW'(Cols - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_last && col_last;

endmodule

// File: rtl/matmul_sched.sv
// Read/accumulate/offer sequencer for a banked N1xN2 systolic matrix multiply.
// Optional MATMUL_SCHED_PERF_EN adds a saturating stall_cnt of OFFER cycles without res_ready.
module matmul_sched
    import matmul_sched_pkg::*;
#(
    parameter int unsigned M    = MDefault,
    parameter int unsigned N1   = N1Default,
    parameter int unsigned N2   = N2Default,
    parameter int unsigned D_W  = DwDefault,
    localparam int unsigned AW  = clog2_min1(M * M / N1),
    localparam int unsigned BW  = clog2_min1(M * M / N2),
    localparam int unsigned RW  = clog2_min1(M / N1),
    localparam int unsigned CW  = clog2_min1(M / N2),
    localparam int unsigned KW  = clog2_min1(max_u(M, N1 + N2 - 1))
) (
    input  logic          fclk,
    input  logic          rst,
    input  logic          start,
    input  logic          res_ready,
    output logic [AW-1:0] rd_addr_A,
    output logic [BW-1:0] rd_addr_B,
    output logic          rd_en,
    output logic          acc_clr,
    output logic          res_valid,
    output logic [RW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic          busy,
`ifdef MATMUL_SCHED_PERF_EN
    output logic [31:0]   stall_cnt,
`endif
    output logic          done
);

    if ((M % N1) != 0 || (M % N2) != 0 || D_W == 0) begin : g_cfg_err
        $fatal(1, "matmul_sched: M must be a multiple of N1 and N2, D_W nonzero");
    end

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          tile_clr, tile_adv, tile_last;

    sched_tile_cnt #(
        .Rows (M / N1),
        .Cols (M / N2)
    ) u_tile_cnt (
        .clk    (fclk),
        .rst    (rst),
        .clr_i  (tile_clr),
        .adv_i  (tile_adv),
        .row_o  (tile_row),
        .col_o  (tile_col),
        .last_o (tile_last)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tile_clr  = 1'b0;
        tile_adv  = 1'b0;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        rd_addr_A = '0;
        rd_addr_B = '0;
        res_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = StStream;
                    k_d      = '0;
                    tile_clr = 1'b1;
                end
            end
            StStream: begin
                rd_en     = 1'b1;
                acc_clr   = (k_q == '0);
                rd_addr_A = AW'(tile_row) * AW'(M) + AW'(k_q);
                rd_addr_B = BW'(tile_col) * BW'(M) + BW'(k_q);
                if (k_q == KW'(M - 1)) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            // Wait for the last operands to ripple through the array skew.
            StDrain: begin
                if (k_q == KW'(N1 + N2 - 2)) begin
                    k_d     = '0;
                    state_d = StOffer;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StOffer: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    tile_adv = 1'b1;
                    state_d  = tile_last ? StDone : StStream;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

`ifdef MATMUL_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && start) begin
            stall_d = '0;
        end else if (state_q == StOffer && !res_ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench: a per-cycle expected trace is built from the tile schedule and
// compared against two scheduler instances (4x4 and 2x4 banking).
module tb_matmul_sched;

    typedef struct packed {
        logic        en;
        logic        clr;
        logic        valid;
        logic        busy;
        logic        done;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [31:0] stall;
    } obs_t;

    logic fclk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic res_ready = 1'b0;

    always #5 fclk = ~fclk;

    logic [3:0] addr_a1, addr_b1;
    logic [4:0] addr_a2;
    logic [3:0] addr_b2;
    logic       en1, clr1, valid1, busy1, done1;
    logic       en2, clr2, valid2, busy2, done2;
    logic [0:0] row1, col1, col2;
    logic [1:0] row2;
    logic [31:0] stall1, stall2;

    matmul_sched #(.M(8), .N1(4), .N2(4), .D_W(8)) u_dut1 (
        .fclk      (fclk),
        .rst       (rst),
        .start     (start1),
        .res_ready (res_ready),
        .rd_addr_A (addr_a1),
        .rd_addr_B (addr_b1),
        .rd_en     (en1),
        .acc_clr   (clr1),
        .res_valid (valid1),
        .tile_row  (row1),
        .tile_col  (col1),
        .busy      (busy1),
`ifdef MATMUL_SCHED_PERF_EN
        .stall_cnt (stall1),
`endif
        .done      (done1)
    );

    matmul_sched #(.M(8), .N1(2), .N2(4), .D_W(8)) u_dut2 (
        .fclk      (fclk),
        .rst       (rst),
        .start     (start2),
        .res_ready (res_ready),
        .rd_addr_A (addr_a2),
        .rd_addr_B (addr_b2),
        .rd_en     (en2),
        .acc_clr   (clr2),
        .res_valid (valid2),
        .tile_row  (row2),
        .tile_col  (col2),
        .busy      (busy2),
`ifdef MATMUL_SCHED_PERF_EN
        .stall_cnt (stall2),
`endif
        .done      (done2)
    );

`ifndef MATMUL_SCHED_PERF_EN
    assign stall1 = '0;
    assign stall2 = '0;
`endif

    bit   sel2 = 1'b0;
    obs_t obs;

    always_comb begin
        obs = '0;
        if (!sel2) begin
            obs.en = en1; obs.clr = clr1; obs.valid = valid1; obs.busy = busy1;
            obs.done = done1; obs.a = 8'(addr_a1); obs.b = 8'(addr_b1);
            obs.row = 8'(row1); obs.col = 8'(col1); obs.stall = stall1;
        end else begin
            obs.en = en2; obs.clr = clr2; obs.valid = valid2; obs.busy = busy2;
            obs.done = done2; obs.a = 8'(addr_a2); obs.b = 8'(addr_b2);
            obs.row = 8'(row2); obs.col = 8'(col2); obs.stall = stall2;
        end
    end

    obs_t exp_q[$];
    bit   rdy_q[$];
    bit   st_q[$];
    bit   rst_q[$];
    int   stall_run[2];
    int   exp_done;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    function automatic bit rnd(input bit en);
        return en ? 1'($urandom) : 1'b0;
    endfunction

    task automatic push(input obs_t o, input bit rdy, input bit st, input bit r);
`ifndef MATMUL_SCHED_PERF_EN
        o.stall = '0;
`endif
        exp_q.push_back(o);
        rdy_q.push_back(rdy);
        st_q.push_back(st);
        rst_q.push_back(r);
    endtask

    // Expected trace of one job. Cycle 0 is the IDLE cycle carrying start.
    task automatic build_job(input int m, input int n1, input int n2, input int first_stall,
                             input int max_stall, input bit noise, input int abort_tile);
        obs_t o;
        int   s;
        int   nst;
        int   tiles;
        int   tidx;
        int   total_stall;
        exp_q.delete(); rdy_q.delete(); st_q.delete(); rst_q.delete();
        s = sel2 ? 1 : 0;
        tiles = (m / n1) * (m / n2);
        total_stall = 0;
        o = '0; o.stall = 32'(stall_run[s]);
        push(o, rnd(noise), 1'b1, 1'b0);
        stall_run[s] = 0;
        for (int r = 0; r < m / n1; r++) begin
            for (int c = 0; c < m / n2; c++) begin
                tidx = r * (m / n2) + c;
                for (int k = 0; k < m; k++) begin
                    o = '0; o.en = 1'b1; o.clr = (k == 0); o.busy = 1'b1;
                    o.a = 8'(r * m + k); o.b = 8'(c * m + k);
                    o.row = 8'(r); o.col = 8'(c); o.stall = 32'(stall_run[s]);
                    push(o, rnd(noise), rnd(noise), 1'b0);
                end
                for (int d = 0; d < n1 + n2 - 1; d++) begin
                    o = '0; o.busy = 1'b1; o.row = 8'(r); o.col = 8'(c);
                    o.stall = 32'(stall_run[s]);
                    if (tidx == abort_tile && d == 2) begin
                        push(o, rnd(noise), 1'b0, 1'b1);
                        push('0, 1'b0, 1'b0, 1'b0);
                        stall_run[0] = 0;
                        stall_run[1] = 0;
                        exp_done = -1;
                        return;
                    end
                    push(o, rnd(noise), rnd(noise), 1'b0);
                end
                nst = (tidx == 0) ? first_stall : $urandom_range(max_stall, 0);
                for (int j = 0; j <= nst; j++) begin
                    o = '0; o.valid = 1'b1; o.busy = 1'b1; o.row = 8'(r); o.col = 8'(c);
                    o.stall = 32'(stall_run[s]);
                    push(o, (j == nst), rnd(noise), 1'b0);
                    if (j < nst) stall_run[s]++;
                end
                total_stall += nst;
            end
        end
        o = '0; o.busy = 1'b1; o.done = 1'b1; o.stall = 32'(stall_run[s]);
        push(o, rnd(noise), 1'b1, 1'b0);
        o = '0; o.stall = 32'(stall_run[s]);
        push(o, rnd(noise), 1'b0, 1'b0);
        exp_done = tiles * (m + n1 + n2) + 1 + total_stall;
    endtask

    task automatic run_queue(input string tag);
        int done_at;
        done_at = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge fclk);
            n_checks++;
            assert (obs === exp_q[i]) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s cycle %0d: observed %h expected %h", tag, i, obs, exp_q[i]);
            end
            if (obs.done === 1'b1 && done_at < 0) done_at = i;
            rst = rst_q[i];
            res_ready = rdy_q[i];
            start1 = sel2 ? 1'b0 : st_q[i];
            start2 = sel2 ? st_q[i] : 1'b0;
        end
        n_checks++;
        assert (done_at == exp_done) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s done_cycle: observed %0d expected %0d", tag, done_at, exp_done);
        end
    endtask

    initial begin
        stall_run[0] = 0;
        stall_run[1] = 0;
        rst = 1'b1;
        repeat (2) @(negedge fclk);

        // Reset state under rst and on the first cycle after release.
        exp_q.delete(); rdy_q.delete(); st_q.delete(); rst_q.delete();
        push('0, 1'b1, 1'b0, 1'b1);
        push('0, 1'b1, 1'b0, 1'b0);
        push('0, 1'b0, 1'b0, 1'b0);
        exp_done = -1;
        run_queue("reset");

        build_job(8, 4, 4, 0, 0, 1'b0, -1);
        run_queue("basic_4x4");

        build_job(8, 4, 4, 5, 0, 1'b1, -1);
        run_queue("stall5_noise");

        build_job(8, 4, 4, 2, 3, 1'b1, -1);
        run_queue("random_stalls");

        build_job(8, 4, 4, 1, 2, 1'b1, 2);
        run_queue("abort_drain_t2");

        build_job(8, 4, 4, 0, 0, 1'b0, -1);
        run_queue("after_abort");

        sel2 = 1'b1;
        build_job(8, 2, 4, 0, 0, 1'b0, -1);
        run_queue("basic_2x4");

        build_job(8, 2, 4, 3, 4, 1'b1, -1);
        run_queue("random_2x4");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
